// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add multiplier: one partial-product step per clock, SIZE steps per product.
// Optional MULT_EARLY_TERMINATE_EN ends the run once the remaining multiplier bits are all zero.
module shift_add_mult_ctrl #(
    parameter int SIZE = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStart,
    input  logic [SIZE-1:0]   iA,
    input  logic [SIZE-1:0]   iB,
    output logic              oBusy,
    output logic              oDone,
    output logic [2*SIZE-1:0] oResult,
    output logic [1:0]        oDbgState
);

    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [2*SIZE-1:0] r_mcand;
    logic [SIZE-1:0]   r_mplier;
    logic [2*SIZE-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic [2*SIZE-1:0] r_result;

    logic [2*SIZE-1:0] w_acc_next;
    logic [SIZE-1:0]   w_mplier_shift;
    logic              w_last;

    always_comb begin
        w_acc_next     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_mplier_shift = r_mplier >> 1;
`ifdef MULT_EARLY_TERMINATE_EN
        w_last = (r_cnt == CW'(SIZE-1)) || (w_mplier_shift == '0);
`else
        w_last = (r_cnt == CW'(SIZE-1));
`endif
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (iStart) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_mcand  <= {{SIZE{1'b0}}, iA};
                        r_mplier <= iB;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shift;
                    r_cnt    <= r_cnt + CW'(1);
                    // Result register includes the final step's addition.
                    if (w_last) r_result <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign oBusy     = (r_state != ST_IDLE);
    assign oDone     = (r_state == ST_DONE);
    assign oResult   = r_result;
    assign oDbgState = r_state;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: expected products and latencies are queued at acceptance.
module tb_shift_add_mult_ctrl;

  localparam int SIZE = 16;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              iStart = 1'b0;
  logic [SIZE-1:0]   iA = '0;
  logic [SIZE-1:0]   iB = '0;
  logic              oBusy;
  logic              oDone;
  logic [2*SIZE-1:0] oResult;
  logic [1:0]        oDbgState;

  shift_add_mult_ctrl #(.SIZE(SIZE)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iA(iA), .iB(iB),
    .oBusy(oBusy), .oDone(oDone), .oResult(oResult), .oDbgState(oDbgState)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cyc = 0;
  int prev_lat = 0;
  bit have_prev = 0;
  bit hold_phase = 0;
  logic [2*SIZE-1:0] last_res = '0;
  logic [2*SIZE-1:0] exp_q[$];
  int lat_q[$];

  task automatic check(input string tag, input logic [2*SIZE-1:0] got, input logic [2*SIZE-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference latency: cycles from accepting edge to the DONE cycle.
  function automatic int exp_lat(input logic [SIZE-1:0] b);
`ifdef MULT_EARLY_TERMINATE_EN
    int m;
    m = 0;
    for (int i = 0; i < SIZE; i++) if (b[i]) m = i + 1;
    if (m < 1) m = 1;
    return m + 1;
`else
    return SIZE + 1;
`endif
  endfunction

  always @(posedge Clock) cyc++;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge Clock) begin
    if (Reset) begin
      exp_q.delete();
      lat_q.delete();
      last_res = '0;
      have_prev = 0;
    end else begin
      if (oDone) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          check("result", oResult, exp_q.pop_front());
          check("latency", 32'(cyc - acc_cyc + 1), 32'(lat_q.pop_front()));
        end
        last_res = oResult;
      end else begin
        check("result_hold", oResult, last_res);
      end
      if (!hold_phase) have_prev = 0;
      if (iStart && !oBusy) begin
        if (hold_phase && have_prev)
          check("interval", 32'(cyc + 1 - acc_cyc), 32'(prev_lat + 1));
        exp_q.push_back({{SIZE{1'b0}}, iA} * {{SIZE{1'b0}}, iB});
        lat_q.push_back(exp_lat(iB));
        prev_lat = exp_lat(iB);
        have_prev = 1;
        acc_cyc = cyc + 1;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (oBusy && n < 60) begin
      @(posedge Clock); #1;
      n++;
    end
    if (oBusy) check("idle_timeout", 1, 0);
  endtask

  task automatic start_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    wait_idle();
    iStart = 1'b1; iA = a; iB = b;
    @(posedge Clock); #1;
    iStart = 1'b0;
    iA = SIZE'($urandom); iB = SIZE'($urandom);
  endtask

  task automatic wait_done();
    int n;
    int d0;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(posedge Clock); #1;
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    start_op(a, b);
    wait_done();
  endtask

  initial begin
    int d0;
    #12;
    check("rst_busy", {31'd0, oBusy}, 0);
    check("rst_done", {31'd0, oDone}, 0);
    check("rst_result", oResult, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;

    // Basic 3*5 with busy rise check.
    start_op(16'd3, 16'd5);
    check("busy_rise", {31'd0, oBusy}, 1);
    wait_done();
    check("res_3x5", oResult, 32'h0000000F);

    run_op(16'hFFFF, 16'hFFFF);
    check("res_max", oResult, 32'hFFFE0001);

    // Early-termination corner operands (latency model covers both builds).
    run_op(16'h1234, 16'd1);
    check("res_b1", oResult, 32'h00001234);
    run_op(16'h1234, 16'd0);
    check("res_b0", oResult, 32'h0);
    run_op(16'h0003, 16'h8000);
    check("res_b8000", oResult, 32'h00018000);

    // Idle stability after done.
    repeat (10) begin
      @(posedge Clock); #1;
      check("idle_done_low", {31'd0, oDone}, 0);
      check("idle_result", oResult, 32'h00018000);
    end

    // Start held high with operands changing every cycle.
    wait_idle();
    hold_phase = 1'b1;
    iStart = 1'b1;
    repeat (4 * (SIZE + 2)) begin
      iA = SIZE'($urandom); iB = SIZE'($urandom);
      @(posedge Clock); #1;
    end
    iStart = 1'b0;
    wait_idle();
    @(posedge Clock); #1;
    hold_phase = 1'b0;

    // Asynchronous reset mid-run.
    start_op(16'd100, 16'd200);
    repeat (7) @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, oBusy}, 0);
    check("abort_done", {31'd0, oDone}, 0);
    check("abort_result", oResult, 0);
    @(posedge Clock); #2;
    Reset = 1'b0;
    d0 = done_cnt;
    repeat (25) @(posedge Clock);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 0);
    run_op(16'd7, 16'd6);
    check("res_7x6", oResult, 32'd42);

    // Random sweep.
    for (int i = 0; i < 1000; i++) run_op(SIZE'($urandom), SIZE'($urandom));
    for (int i = 0; i < 20; i++) run_op(SIZE'($urandom), SIZE'($urandom_range(0, 15)));

    repeat (3) @(posedge Clock);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
# shift_add_mult_ctrl

Sequential shift-and-add multiplier controller. It accepts an unsigned operand pair on a start request and sequences one partial-product step per clock over an internal accumulator. It returns the full-width product with a one-cycle done pulse. It sits beside the combinational multiplier cells as the area-cheap, multi-cycle alternative, and any FSM that needs a product and can tolerate variable latency drives it directly.

## Interface
- SIZE, 16, operand width in bits; product is 2*SIZE bits; SIZE >= 2.

- Clock  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- iStart  input  1  start request; sampled only in IDLE.
- iA  input  SIZE  multiplicand, unsigned; captured when start is accepted.
- iB  input  SIZE  multiplier, unsigned; captured when start is accepted.
- oBusy  output  1  high in RUN and DONE; low in IDLE.
- oDone  output  1  one-cycle pulse, high only in DONE.
- oResult  output  2*SIZE  product register; valid from the DONE cycle, held until the next DONE.

One clock; reset is asynchronous and active-high.

## Operation
- Internal registers:
  - mcand: 2*SIZE bits.
  - mplier: SIZE bits.
  - acc: 2*SIZE bits.
  - cnt: ceil(log2(SIZE)) bits, minimum 1 bit.
  - state.
- States: IDLE, RUN, DONE.
- IDLE with iStart=1 at a clock edge:
  - mcand <= zero-extended iA, mplier <= iB, acc <= 0, cnt <= 0.
  - state <= RUN.
- IDLE with iStart=0: hold.
- RUN, each cycle:
  - If mplier[0]=1, acc <= acc + mcand, computed modulo 2^(2*SIZE). Overflow is impossible for unsigned operands.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
- RUN exit:
  - When cnt == SIZE-1 (the last step), state <= DONE.
  - On the same edge, oResult <= the final acc value, including that step's addition.
- DONE: oDone=1 for exactly this cycle; state <= IDLE unconditionally.
- iStart in RUN or DONE is ignored. No queueing: a start must be reasserted in IDLE.
- iA and iB are don't-care outside the accepting edge.
- Reset asserted in any state, including mid-RUN:
  - state=IDLE; oBusy=0, oDone=0, oResult=0; all internal registers 0.
  - No done pulse is produced for an aborted operation.

## Timing
- Reset values: oBusy=0, oDone=0, oResult=0.
- Let the start be accepted at edge E0.
  - RUN occupies the cycles after E0 through edge E_SIZE.
  - DONE is the cycle after E_SIZE, so oDone is high SIZE+1 cycles after the accepting edge.
  - IDLE resumes the following cycle.
- Earliest next accept is the edge ending the first IDLE cycle. Back-to-back throughput is one product per SIZE+2 cycles.
- oResult changes only on the edge entering DONE (or on reset). It is stable at all other times.
- oBusy and oDone are decoded from the state register only, with no combinational path from inputs.

## Configuration
- Macro: MULT_EARLY_TERMINATE_EN.
- Defined:
  - RUN also exits to DONE when the shifted mplier (its value after this step's shift) is zero.
  - RUN lasts max(1, msb_index(iB)+1) cycles. For iB=0, RUN lasts 1 cycle and the result is 0.
  - The result is identical to the non-early-terminate result. Only the latency shrinks.
- Undefined: RUN always lasts exactly SIZE cycles regardless of operand values.

## Test plan
- SIZE=16, iA=3, iB=5, single iStart pulse in IDLE. Required response:
  - oBusy rises the next cycle.
  - oDone pulses exactly once, 17 cycles after the accepting edge.
  - oResult=32'h0000000F.
- iA=16'hFFFF, iB=16'hFFFF. Required response: oResult=32'hFFFE0001. Also run a random sweep of 1000 pairs against a reference product, checking that none mismatch.
- iStart held high continuously:
  - One product per 18 cycles.
  - Operands change during RUN are ignored.
  - oResult reflects only the values captured at each accepting edge.
- Start iA=100, iB=200, then assert Reset asynchronously (between clock edges) at RUN cycle 8. Required response:
  - oBusy=0 and oResult=0 immediately.
  - No oDone pulse.
  - A following start with iA=7, iB=6 yields 42.
- With MULT_EARLY_TERMINATE_EN defined:
  - iB=1 gives oDone 2 cycles after the accepting edge, result=iA.
  - iB=0 gives oDone 2 cycles after the accepting edge, result=0.
  - iB=16'h8000 gives oDone 17 cycles after the accepting edge.
- Start accepted and oDone observed, then iStart held low for 10 cycles. Required response: oResult remains stable and oDone stays low.
